diffamp_bank_cal: RTL
=====================

DIFFAMP_BANK_CAL -- requirements
Module: diffamp_bank_cal

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning):
  NCH, 2, number of differential amplifier channels.
  TRIM_BITS, 6, offset-trim code width per channel.
  SETTLE_CYC, 2, clock cycles allowed for settling after each SAR trial.
  GSEL_W, 2, gain-select width.
  GAIN_BASE, 10.0, differential gain at gain_sel=0.
  TRIM_LSB, 1e-3, trim step in volts.
  VCM, 1.5, output common-mode in volts.
  VDD, 3.0, output clamp ceiling in volts.
REQ-002 Ports SHALL be as follows, one per line (name, direction, width, meaning):
  clk, input, 1, single clock.
  rst, input, 1, asynchronous active-high reset.
  cal_start, input, 1, calibration request, level-sampled on clk rise.
  gain_sel, input, GSEL_W, gain exponent.
  inp, input, xreal[NCH], positive inputs.
  inn, input, xreal[NCH], negative inputs.
  vos, input, xreal[NCH], intrinsic input offset per channel (mismatch model).
  outp, output, xreal[NCH], positive outputs.
  outn, output, xreal[NCH], negative outputs.
  trim_code, output, NCH*TRIM_BITS, per-channel trim codes, channel 0 in the LSBs.
  cal_busy, output, 1, high while calibration runs.
  cal_done, output, 1, one-cycle pulse at completion.
  cal_ch, output, clog2(NCH) (min 1), channel currently under calibration.

Function
REQ-003 Per channel k: vd = A*(vin_d + vos[k] - vtrim[k]), where A = GAIN_BASE*2^gain_sel, vin_d = inp[k]-inn[k], and vtrim[k] = (trim_code[k] - 2^(TRIM_BITS-1))*TRIM_LSB.
REQ-004 outp = VCM+vd/2 and outn = VCM-vd/2, each clamped to [0, VDD]; outputs SHALL update continuously (event-driven), not on clk.
REQ-005 While cal_busy, the channel equal to cal_ch SHALL use vin_d=0 (inputs shorted); other channels SHALL operate normally.
REQ-006 The FSM SHALL have states IDLE, TRIAL, SETTLE, DECIDE, NEXT, DONE.
REQ-007 IDLE->TRIAL SHALL occur on a clk rise with cal_start=1: cal_ch=0, cal_busy=1, trim_code[0]=0, bit index=TRIM_BITS-1.
REQ-008 TRIAL (1 cycle) SHALL set the current bit of trim_code[cal_ch], then go to SETTLE.
REQ-009 SETTLE SHALL last SETTLE_CYC-1 cycles (skipped if SETTLE_CYC=1), then go to DECIDE.
REQ-010 DECIDE (1 cycle) SHALL keep the bit if outp>outn (strict) and clear it otherwise. If bit index>0, the index SHALL decrement and the FSM SHALL go to TRIAL; otherwise it SHALL go to NEXT.
REQ-011 Each bit SHALL therefore take SETTLE_CYC+1 cycles.
REQ-012 NEXT (1 cycle): if cal_ch<NCH-1, cal_ch SHALL increment, the next channel code SHALL clear to 0, and the FSM SHALL go to TRIAL; else it SHALL go to DONE.
REQ-013 DONE (1 cycle): cal_done=1, cal_busy=0, then IDLE; cal_ch SHALL hold its last value.
REQ-014 Latency from accepting edge to the cal_done cycle SHALL be NCH*(TRIM_BITS*(SETTLE_CYC+1)+1)+1 cycles.
REQ-015 Final code SHALL be the largest c in [0, 2^TRIM_BITS-1] with vos - (c-2^(TRIM_BITS-1))*TRIM_LSB > 0, or 0 if none exists; saturation at all-ones SHALL occur when vos exceeds the range.
REQ-016 cal_start while cal_busy SHALL be ignored; cal_start held high SHALL restart calibration only after returning to IDLE.
REQ-017 gain_sel changes mid-calibration SHALL take effect immediately and SHALL NOT alter the comparator decision sign.

Reset
REQ-018 rst=1 SHALL asynchronously force IDLE, cal_busy=0, cal_done=0, cal_ch=0, and every trim_code to 2^(TRIM_BITS-1) (midscale, vtrim=0), including mid-calibration.
REQ-019 Operation SHALL resume on the first clk rise after rst deasserts.

Verification (defaults; inputs tied inp=inn=1.5)
REQ-020 vos={+10.4mV,-5.6mV}, gain_sel=0, pulse cal_start -> cal_done exactly 39 cycles after accepting edge; trim_code={42,26}.
REQ-021 vos[0]=+10.0mV -> code 41 (strict compare); vos[0]=-40mV -> code 0; vos[0]=+40mV -> code 63.
REQ-022 After REQ-020, apply inp[0]-inn[0]=+5mV at gain_sel=1 -> outp[0]-outn[0] = 20*(5+0.4)mV = 108mV +/-1e-9.
REQ-023 Assert rst at cycle 12 of calibration -> immediately cal_busy=0, all codes=32; restart completes normally.
REQ-024 Pulse cal_start again at cycle 5 of calibration -> no effect; single cal_done at cycle 39.
REQ-025 vos[0]=+1V, gain_sel=3 -> outp[0] clamps to 3.0 and outn[0] to 0.0 before calibration.

Source files
------------

// File: rtl/diffamp_bank_cal.sv
`default_nettype none
// ----------------------------------------------------------------------------
// diffamp_bank_cal
// Behavioural bank of NCH differential amplifiers with real-valued I/O and a
// sequential SAR engine that trims each channel's input offset in turn.
// Rev 1.0
// ----------------------------------------------------------------------------
module diffamp_bank_cal #(
  parameter int  NCH        = 2,
  parameter int  TRIM_BITS  = 6,
  parameter int  SETTLE_CYC = 2,
  parameter int  GSEL_W     = 2,
  parameter real GAIN_BASE  = 10.0,
  parameter real TRIM_LSB   = 1e-3,
  parameter real VCM        = 1.5,
  parameter real VDD        = 3.0,
  localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cal_start,
  input  logic [GSEL_W-1:0]        gain_sel,
  input  real                      inp [NCH],
  input  real                      inn [NCH],
  input  real                      vos [NCH],
  output real                      outp [NCH],
  output real                      outn [NCH],
  output logic [NCH*TRIM_BITS-1:0] trim_code,
  output logic                     cal_busy,
  output logic                     cal_done,
  output logic [CH_W-1:0]          cal_ch
);

  localparam int BI_W = (TRIM_BITS > 1) ? $clog2(TRIM_BITS) : 1;
  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  // Midscale code: zero trim voltage.
  localparam logic [TRIM_BITS-1:0] MID = {1'b1, {(TRIM_BITS-1){1'b0}}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_TRIAL  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [BI_W-1:0]      bit_q, bit_d;
  logic [SC_W-1:0]      cnt_q, cnt_d;
  logic [TRIM_BITS-1:0] code_q [NCH];
  logic [TRIM_BITS-1:0] code_d [NCH];
  logic                 cmp;

  // Comparator: sign of the differential output of the channel being trimmed.
  assign cmp = outp[ch_q] > outn[ch_q];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; SETTLE is bypassed entirely when one cycle suffices.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cal_start) state_d = S_TRIAL;
      S_TRIAL:  state_d = (SETTLE_CYC > 1) ? S_SETTLE : S_DECIDE;
      S_SETTLE: if (cnt_q == SC_W'(SETTLE_CYC - 2)) state_d = S_DECIDE;
      S_DECIDE: state_d = (bit_q != '0) ? S_TRIAL : S_NEXT;
      S_NEXT:   state_d = (ch_q != CH_W'(NCH - 1)) ? S_TRIAL : S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs; cal_ch keeps pointing at the last channel after completion.
  always_comb begin
    cal_busy = (state_q == S_TRIAL) || (state_q == S_SETTLE) ||
               (state_q == S_DECIDE) || (state_q == S_NEXT);
    cal_done = (state_q == S_DONE);
    cal_ch   = ch_q;
  end

  // SAR datapath next values: channel pointer, bit pointer, settle count, codes.
  always_comb begin
    ch_d   = ch_q;
    bit_d  = bit_q;
    cnt_d  = cnt_q;
    code_d = code_q;
    case (state_q)
      S_IDLE: begin
        if (cal_start) begin
          ch_d      = '0;
          bit_d     = BI_W'(TRIM_BITS - 1);
          code_d[0] = '0;
        end
      end
      S_TRIAL: begin
        code_d[ch_q][bit_q] = 1'b1;
        cnt_d               = '0;
      end
      S_SETTLE: cnt_d = cnt_q + 1'b1;
      S_DECIDE: begin
        if (!cmp)          code_d[ch_q][bit_q] = 1'b0;
        if (bit_q != '0)   bit_d = bit_q - 1'b1;
      end
      S_NEXT: begin
        if (ch_q != CH_W'(NCH - 1)) begin
          ch_d         = ch_q + 1'b1;
          bit_d        = BI_W'(TRIM_BITS - 1);
          code_d[ch_d] = '0;
        end
      end
      default: ;
    endcase
  end

  // SAR datapath registers; reset parks every channel at midscale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q  <= '0;
      bit_q <= '0;
      cnt_q <= '0;
      for (int k = 0; k < NCH; k++) code_q[k] <= MID;
    end else begin
      ch_q   <= ch_d;
      bit_q  <= bit_d;
      cnt_q  <= cnt_d;
      code_q <= code_d;
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_pack
    assign trim_code[k*TRIM_BITS +: TRIM_BITS] = code_q[k];
  end

  // Amplifier transfer, event-driven: channel under calibration sees a shorted input.
  always_comb begin
    real vind, vtrim, gain, vd, vp, vn;
    for (int k = 0; k < NCH; k++) begin
      vind    = (cal_busy && (int'(ch_q) == k)) ? 0.0 : (inp[k] - inn[k]);
      vtrim   = (real'(code_q[k]) - real'(MID)) * TRIM_LSB;
      gain    = GAIN_BASE * real'(32'd1 << gain_sel);
      vd      = gain * (vind + vos[k] - vtrim);
      vp      = VCM + vd / 2.0;
      vn      = VCM - vd / 2.0;
      outp[k] = (vp < 0.0) ? 0.0 : ((vp > VDD) ? VDD : vp);
      outn[k] = (vn < 0.0) ? 0.0 : ((vn > VDD) ? VDD : vn);
    end
  end

endmodule
`default_nettype wire
